// File: rtl/pll_drp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_drp_ctrl_pkg
// Description : Shared FSM encoding, table entry geometry and the DRP
//               read-modify-write merge helper.
// Revision    : 1.0
// ============================================================================
package pll_drp_ctrl_pkg;

    localparam int c_ADDR_W  = 7;
    localparam int c_MASK_W  = 16;
    localparam int c_DATA_W  = 16;
    localparam int c_ENTRY_W = c_ADDR_W + c_MASK_W + c_DATA_W;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_ASSERT_RST = 4'd1,
        ST_READ       = 4'd2,
        ST_WAIT_R     = 4'd3,
        ST_WRITE      = 4'd4,
        ST_WAIT_W     = 4'd5,
        ST_NEXT       = 4'd6,
        ST_WAIT_LOCK  = 4'd7
    } state_t;

    // A mask bit of 1 keeps the read-back bit; 0 takes the table bit.
    function automatic logic [c_DATA_W-1:0] merge_bits(
        input logic [c_DATA_W-1:0] rd,
        input logic [c_MASK_W-1:0] mask,
        input logic [c_DATA_W-1:0] data
    );
        return (rd & mask) | (data & ~mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_drp_rom.sv
`default_nettype none
// ============================================================================
// Module      : pll_drp_rom
// Description : Combinational lookup of the two reconfiguration tables.
// Revision    : 1.0
// ============================================================================
module pll_drp_rom
    import pll_drp_ctrl_pkg::*;
#(
    parameter int                              N_REGS   = 8,
    parameter int                              IDX_W    = 3,
    parameter logic [2*N_REGS*c_ENTRY_W-1:0]   ROM_INIT = '0
) (
    input  logic                  i_sel,
    input  logic [IDX_W-1:0]      i_idx,
    output logic [c_ADDR_W-1:0]   o_addr,
    output logic [c_MASK_W-1:0]   o_mask,
    output logic [c_DATA_W-1:0]   o_data
);

    localparam int NUM_W = $clog2(2 * N_REGS);

    logic [c_ENTRY_W-1:0] w_tbl [2*N_REGS];
    logic [NUM_W-1:0]     w_num;

    genvar gi;
    generate
        for (gi = 0; gi < 2 * N_REGS; gi++) begin : g_entry
            assign w_tbl[gi] = ROM_INIT[gi*c_ENTRY_W +: c_ENTRY_W];
        end
    endgenerate

    // Table 1 starts at entry N_REGS; this equals {sel, idx} whenever
    // N_REGS is a power of two and stays packed otherwise.
    assign w_num = i_sel ? (NUM_W'(N_REGS) + NUM_W'(i_idx)) : NUM_W'(i_idx);

    assign {o_addr, o_mask, o_data} = w_tbl[w_num];

endmodule
`default_nettype wire

// File: rtl/pll_drp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_drp_ctrl
// Description : PLL reconfiguration sequencer: holds the PLL in reset and
//               read-modify-writes N_REGS DRP registers, then waits for lock.
// Revision    : 1.0
// ============================================================================
module pll_drp_ctrl
    import pll_drp_ctrl_pkg::*;
#(
    parameter int                              N_REGS       = 8,
    parameter logic [2*N_REGS*c_ENTRY_W-1:0]   ROM_INIT     = '0,
    parameter int                              DRDY_TIMEOUT = 255
) (
    input  logic                  DCLK,
    input  logic                  RST,
    input  logic                  SEN,
    input  logic                  SADDR,
    output logic                  SRDY,
    output logic                  BUSY,
    output logic                  ERR,
    output logic [c_ADDR_W-1:0]   DADDR,
    output logic                  DEN,
    output logic                  DWE,
    output logic [c_DATA_W-1:0]   DI,
    input  logic [c_DATA_W-1:0]   DO,
    input  logic                  DRDY,
    input  logic                  LOCKED,
    output logic                  RST_PLL
);

    localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int CNT_W = $clog2(DRDY_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_REGS - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DRDY_TIMEOUT - 1);

    state_t                r_state, w_state_nxt;
    logic                  r_sel,   w_sel_nxt;
    logic [IDX_W-1:0]      r_idx,   w_idx_nxt;
    logic [CNT_W-1:0]      r_cnt,   w_cnt_nxt;
    logic                  r_err,   w_err_nxt;
    logic                  r_srdy,  w_srdy_nxt;
    logic [c_ADDR_W-1:0]   r_daddr, w_daddr_nxt;
    logic [c_DATA_W-1:0]   r_di,    w_di_nxt;

    logic [c_ADDR_W-1:0]   w_rom_addr;
    logic [c_MASK_W-1:0]   w_rom_mask;
    logic [c_DATA_W-1:0]   w_rom_data;

    // The table is looked up with the upcoming index so DADDR can be
    // registered on the same edge that enters READ.
    pll_drp_rom #(
        .N_REGS   (N_REGS),
        .IDX_W    (IDX_W),
        .ROM_INIT (ROM_INIT)
    ) u_rom (
        .i_sel  (r_sel),
        .i_idx  (w_idx_nxt),
        .o_addr (w_rom_addr),
        .o_mask (w_rom_mask),
        .o_data (w_rom_data)
    );

    always_comb begin
        w_idx_nxt = r_idx;
        if (r_state == ST_IDLE && SEN) begin
            w_idx_nxt = '0;
        end else if (r_state == ST_NEXT && r_idx != c_LAST_IDX) begin
            w_idx_nxt = r_idx + IDX_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_srdy_nxt  = 1'b0;
        w_daddr_nxt = r_daddr;
        w_di_nxt    = r_di;
        case (r_state)
            ST_IDLE: begin
                if (SEN) begin
                    w_state_nxt = ST_ASSERT_RST;
                    w_sel_nxt   = SADDR;
                    w_err_nxt   = 1'b0;
                end
            end
            ST_ASSERT_RST: begin
                w_state_nxt = ST_READ;
                w_daddr_nxt = w_rom_addr;
            end
            ST_READ: begin
                w_state_nxt = ST_WAIT_R;
                w_cnt_nxt   = '0;
            end
            ST_WAIT_R: begin
                if (DRDY) begin
                    w_di_nxt    = merge_bits(DO, w_rom_mask, w_rom_data);
                    w_state_nxt = ST_WRITE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_WAIT_W;
                w_cnt_nxt   = '0;
            end
            ST_WAIT_W: begin
                if (DRDY) begin
                    w_state_nxt = ST_NEXT;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_NEXT: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else begin
                    w_state_nxt = ST_READ;
                    w_daddr_nxt = w_rom_addr;
                end
            end
            ST_WAIT_LOCK: begin
                if (LOCKED) begin
                    w_srdy_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge DCLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_sel   <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_srdy  <= 1'b0;
            r_daddr <= '0;
            r_di    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_srdy  <= w_srdy_nxt;
            r_daddr <= w_daddr_nxt;
            r_di    <= w_di_nxt;
        end
    end

    // READ/WRITE are single-cycle states always followed by a wait state,
    // so DEN can never stay high across two cycles.
    assign DEN     = (r_state == ST_READ) || (r_state == ST_WRITE);
    assign DWE     = (r_state == ST_WRITE);
    assign BUSY    = (r_state != ST_IDLE);
    assign RST_PLL = (r_state != ST_IDLE) && (r_state != ST_WAIT_LOCK);
    assign SRDY    = r_srdy;
    assign ERR     = r_err;
    assign DADDR   = r_daddr;
    assign DI      = r_di;

endmodule
`default_nettype wire

// File: tb/tb_pll_drp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_drp_ctrl
// Description : Directed scoreboard bench for pll_drp_ctrl with DRP/PLL models.
// Revision    : 1.0
// ============================================================================
module tb_pll_drp_ctrl;

    localparam logic [38:0] c_E0 = {7'h08, 16'h1000, 16'h0041};
    localparam logic [38:0] c_E1 = {7'h09, 16'hFF00, 16'h00AB};
    localparam logic [38:0] c_E2 = {7'h14, 16'h0000, 16'h1234};
    localparam logic [38:0] c_E3 = {7'h4E, 16'h00FF, 16'hA500};
    localparam logic [155:0] c_ROM = {c_E3, c_E2, c_E1, c_E0};

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        sen;
    logic        saddr;
    logic        srdy, busy, err, den, dwe, rst_pll;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] dout;
    logic        drdy;
    logic        locked;

    int   checks   = 0;
    int   failures = 0;
    int   den_cnt  = 0;
    int   srdy_cnt = 0;
    txn_t sb[$];

    bit        respond = 1'b1;
    logic [2:0] drdy_pipe = 3'b000;
    int        lock_cnt = 0;
    logic      prev_den = 1'b0;
    logic      prev_srdy = 1'b0;

    pll_drp_ctrl #(
        .N_REGS       (2),
        .ROM_INIT     (c_ROM),
        .DRDY_TIMEOUT (16)
    ) dut (
        .DCLK    (clk),
        .RST     (rst),
        .SEN     (sen),
        .SADDR   (saddr),
        .SRDY    (srdy),
        .BUSY    (busy),
        .ERR     (err),
        .DADDR   (daddr),
        .DEN     (den),
        .DWE     (dwe),
        .DI      (di),
        .DO      (dout),
        .DRDY    (drdy),
        .LOCKED  (locked),
        .RST_PLL (rst_pll)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // DRP model: reads return 0xFFFF, DRDY arrives 3 cycles after DEN.
    assign dout = 16'hFFFF;
    assign drdy = drdy_pipe[2];
    always @(posedge clk) drdy_pipe <= {drdy_pipe[1:0], den & respond};

    // PLL model: LOCKED rises 10 cycles after RST_PLL falls.
    initial locked = 1'b0;
    always @(posedge clk) begin
        if (rst_pll) begin
            lock_cnt <= 0;
            locked   <= 1'b0;
        end else if (lock_cnt < 10) begin
            lock_cnt <= lock_cnt + 1;
            if (lock_cnt == 9) locked <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [38:0] entry(input logic sel, input int idx);
        case ({sel, idx[0]})
            2'b00:   return c_E0;
            2'b01:   return c_E1;
            2'b10:   return c_E2;
            default: return c_E3;
        endcase
    endfunction

    task automatic push_cfg(input logic sel);
        for (int i = 0; i < 2; i++) begin
            logic [38:0] e;
            txn_t t;
            e      = entry(sel, i);
            t.we   = 1'b0;
            t.addr = e[38:32];
            t.di   = 16'h0000;
            sb.push_back(t);
            t.we   = 1'b1;
            t.di   = (16'hFFFF & e[31:16]) | (e[15:0] & ~e[31:16]);
            sb.push_back(t);
        end
    endtask

    task automatic pulse_sen(input logic sel);
        sen   = 1'b1;
        saddr = sel;
        @(negedge clk);
        sen   = 1'b0;
        saddr = 1'b0;
    endtask

    task automatic wait_srdy(input string tag);
        int n = 0;
        while (!srdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, srdy, 1);
    endtask

    // Protocol monitor and scoreboard consumer.
    always @(negedge clk) begin
        if (den) begin
            txn_t t;
            den_cnt++;
            check("den_back_to_back", prev_den, 0);
            check("rst_pll_during_drp", rst_pll, 1);
            check("sb_has_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                t = sb.pop_front();
                check("dwe", dwe, t.we);
                check("daddr", daddr, t.addr);
                if (t.we) check("di", di, t.di);
            end
        end
        if (dwe) check("dwe_without_den", den, 1);
        if (srdy) begin
            srdy_cnt++;
            check("srdy_width", prev_srdy, 0);
        end
        prev_den  = den;
        prev_srdy = srdy;
    end

    initial begin
        int n;
        int den0;
        int srdy0;
        rst   = 1'b1;
        sen   = 1'b0;
        saddr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {srdy, busy, err, den, dwe, rst_pll}, 0);
        check("rst_daddr_di", {daddr, di}, 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        // Table 0 reconfiguration
        den0 = den_cnt; srdy0 = srdy_cnt;
        push_cfg(1'b0);
        pulse_sen(1'b0);
        check("busy_after_sen", busy, 1);
        check("rst_pll_after_sen", rst_pll, 1);
        wait_srdy("t0_srdy");
        check("t0_busy_at_srdy", busy, 0);
        repeat (20) @(negedge clk);
        check("t0_den_pulses", den_cnt - den0, 4);
        check("t0_srdy_count", srdy_cnt - srdy0, 1);
        check("t0_sb_drained", sb.size(), 0);

        // Second SEN while busy is ignored
        den0 = den_cnt; srdy0 = srdy_cnt;
        push_cfg(1'b0);
        pulse_sen(1'b0);
        repeat (4) @(negedge clk);
        pulse_sen(1'b1);
        wait_srdy("busy_sen_srdy");
        repeat (40) @(negedge clk);
        check("busy_sen_den_pulses", den_cnt - den0, 4);
        check("busy_sen_srdy_count", srdy_cnt - srdy0, 1);
        check("busy_sen_idle", busy, 0);

        // Table 1 address order
        den0 = den_cnt;
        push_cfg(1'b1);
        pulse_sen(1'b1);
        wait_srdy("t1_srdy");
        repeat (20) @(negedge clk);
        check("t1_den_pulses", den_cnt - den0, 4);
        check("t1_sb_drained", sb.size(), 0);

        // DRDY timeout in WAIT_R
        srdy0 = srdy_cnt;
        respond = 1'b0;
        begin
            txn_t t;
            t.we = 1'b0; t.addr = c_E0[38:32]; t.di = 16'h0;
            sb.push_back(t);
        end
        pulse_sen(1'b0);
        n = 0;
        while (!den && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("to_read_seen", den, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err && n < 100);
        check("to_cycles_to_err", n, 17);
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        check("to_rst_pll", rst_pll, 0);
        repeat (20) @(negedge clk);
        check("to_no_srdy", srdy_cnt - srdy0, 0);
        check("to_err_sticky", err, 1);
        respond = 1'b1;

        // Next SEN clears ERR and completes
        push_cfg(1'b0);
        pulse_sen(1'b0);
        check("err_cleared_by_sen", err, 0);
        wait_srdy("after_to_srdy");
        repeat (20) @(negedge clk);
        check("after_to_sb_drained", sb.size(), 0);

        // RST asserted in WAIT_W
        push_cfg(1'b1);
        pulse_sen(1'b1);
        n = 0;
        while (!(den && dwe) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wr_seen", den & dwe, 1);
        @(negedge clk);
        check("in_wait_w", {busy, den}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {srdy, busy, err, den, dwe, rst_pll}, 0);
        check("midrst_daddr_di", {daddr, di}, 0);
        rst = 1'b0;
        sb.delete();
        repeat (15) @(negedge clk);

        // Fresh SEN after abort
        den0 = den_cnt; srdy0 = srdy_cnt;
        push_cfg(1'b0);
        pulse_sen(1'b0);
        wait_srdy("post_rst_srdy");
        repeat (20) @(negedge clk);
        check("post_rst_den_pulses", den_cnt - den0, 4);
        check("post_rst_srdy_count", srdy_cnt - srdy0, 1);
        check("post_rst_sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
